// File: rtl/xor_stream_if.sv
// xor_stream_if: valid/ready stream plus seed-load bundle for xor_stream_descrambler.
interface xor_stream_if #(
    parameter int WIDTH      = 8,
    parameter int LFSR_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  seed_load;
    logic [LFSR_WIDTH-1:0] seed_in;
    modport master (
        output in_valid, in_data, out_ready, seed_load, seed_in,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready, seed_load, seed_in,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/xor_stream_descrambler.sv
// xor_stream_descrambler: out = in ^ Galois-LFSR keystream, single-entry output register.
// Optional XOR_PARITY_CHECK_EN adds plaintext parity checking with a saturating error counter.
module xor_stream_descrambler #(
    parameter int                    WIDTH      = 8,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] POLY       = 16'hB400,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
`ifdef XOR_PARITY_CHECK_EN
    input  logic       in_parity,
    output logic       out_perr,
    output logic [7:0] err_count,
`endif
    xor_stream_if.slave bus
);
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic                  in_ready, accept;
    logic [WIDTH-1:0]      plain;

    // One keystream word consumes WIDTH Galois steps.
    function automatic logic [LFSR_WIDTH-1:0] advance(input logic [LFSR_WIDTH-1:0] s);
        logic [LFSR_WIDTH-1:0] t;
        t = s;
        for (int i = 0; i < WIDTH; i++) t = t[0] ? ((t >> 1) ^ POLY) : (t >> 1);
        return t;
    endfunction

    always_comb begin
        in_ready    = !bus.seed_load && (!out_valid_q || bus.out_ready);
        accept      = bus.in_valid && in_ready;
        plain       = bus.in_data ^ lfsr_q[WIDTH-1:0];
        lfsr_d      = bus.seed_load ? ((bus.seed_in == '0) ? SEED : bus.seed_in)
                    : accept        ? advance(lfsr_q) : lfsr_q;
        out_valid_d = accept ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
        out_data_d  = accept ? plain : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q      <= SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

`ifdef XOR_PARITY_CHECK_EN
    logic       perr_q, perr_d, bad;
    logic [7:0] err_q, err_d;

    always_comb begin
        bad    = (^plain) != in_parity;
        perr_d = accept ? bad : perr_q;
        err_d  = bus.seed_load ? 8'h00
               : (accept && bad && err_q != 8'hFF) ? err_q + 8'h01 : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
            err_q  <= 8'h00;
        end else begin
            perr_q <= perr_d;
            err_q  <= err_d;
        end
    end

    assign out_perr  = perr_q;
    assign err_count = err_q;
`endif
endmodule

// File: tb/tb_xor_stream_descrambler.sv
// tb_xor_stream_descrambler: directed vector table, round trip against a reference LFSR, reset corners.
module tb_xor_stream_descrambler;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    xor_stream_if #(.WIDTH(8), .LFSR_WIDTH(16)) bus ();

`ifdef XOR_PARITY_CHECK_EN
    logic       in_parity;
    logic       out_perr;
    logic [7:0] err_count;
`endif

    xor_stream_descrambler dut (
        .clk       (clk),
        .reset     (reset),
`ifdef XOR_PARITY_CHECK_EN
        .in_parity (in_parity),
        .out_perr  (out_perr),
        .err_count (err_count),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [7:0]  din;
        logic        ordy;
        logic        sl;
        logic [15:0] seed;
        logic        e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = 16'h0000;
`ifdef XOR_PARITY_CHECK_EN
        in_parity     = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference keystream generator, written independently as a bit-serial shift.
    function automatic logic [15:0] ref_next(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int k = 0; k < 8; k++) begin
            if (r[0]) r = {1'b0, r[15:1]} ^ 16'hB400;
            else      r = {1'b0, r[15:1]};
        end
        return r;
    endfunction

    logic [7:0] plain_q[256];
    logic [7:0] scr[256];

    initial begin
        reset = 1'b1;
        idle_inputs();
        //               iv  din    ordy sl  seed      rdy ov  od
        vt[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hE1};
        vt[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hC4};
        vt[2]  = '{1'b1, 8'h00, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 8'hC4};
        vt[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hE1};
        vt[4]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hE1};
        vt[5]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hE1};
        vt[6]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hE1};
        vt[7]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h3B};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h3B};
        vt[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h62};
        vt[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 8'h62};
        vt[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h34};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 8'h34};
        vt[13] = '{1'b1, 8'h5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hBB};

        do_reset();
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'h0);
        check("reset out_data", 32'(bus.out_data), 32'h00);
        check("reset in_ready", 32'(bus.in_ready), 32'h1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.in_valid  = vt[i].iv;
            bus.in_data   = vt[i].din;
            bus.out_ready = vt[i].ordy;
            bus.seed_load = vt[i].sl;
            bus.seed_in   = vt[i].seed;
            #1;
            check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vt[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
            check($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(vt[i].e_od));
        end

        // Round trip: scramble with the reference keystream, expect plaintext back in order.
        begin
            logic [15:0] r;
            int sent, got, cyc;
            r = 16'hACE1;
            for (int k = 0; k < 256; k++) begin
                plain_q[k] = 8'($urandom);
                scr[k]     = plain_q[k] ^ r[7:0];
                r          = ref_next(r);
            end
            do_reset();
            sent = 0;
            got  = 0;
            cyc  = 0;
            while (got < 256 && cyc < 5000) begin
                @(negedge clk);
                bus.in_valid  = (sent < 256) && ($urandom_range(0, 3) != 0);
                bus.in_data   = (sent < 256) ? scr[sent] : 8'h00;
                bus.out_ready = $urandom_range(0, 2) != 0;
                #1;
                if (bus.out_valid && bus.out_ready) begin
                    check($sformatf("rt word %0d", got), 32'(bus.out_data), 32'(plain_q[got]));
                    got++;
                end
                if (bus.in_valid && bus.in_ready) sent++;
                @(posedge clk);
                cyc++;
            end
            check("rt words received", 32'(got), 32'd256);
            @(negedge clk);
            idle_inputs();
        end

        // Reset while a word is pending discards it and restarts the keystream.
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        @(posedge clk);
        #1;
        check("pend out_valid", 32'(bus.out_valid), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post reset key", 32'(bus.out_data), 32'hE1);

`ifdef XOR_PARITY_CHECK_EN
        do_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        in_parity     = 1'b0;
        @(posedge clk);
        #1;
        check("par w0 perr", 32'(out_perr), 32'h0);
        check("par w0 count", 32'(err_count), 32'h0);
        @(posedge clk);
        #1;
        check("par w1 perr", 32'(out_perr), 32'h1);
        check("par w1 count", 32'(err_count), 32'h1);
        check("par w1 out_valid", 32'(bus.out_valid), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("par reset out_valid", 32'(bus.out_valid), 32'h0);
        check("par reset count", 32'(err_count), 32'h0);
        check("par reset perr", 32'(out_perr), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
